divisor_secuencial: RTL

//   Sequential restoring divider, the inverse companion of the shift-add multiplier.

---
 rtl/divisor_secuencial_if.sv | 30 +++
 rtl/divisor_secuencial.sv | 137 +++++++++++++
 2 files changed

// File: rtl/divisor_secuencial_if.sv
// ============================================================================
//  Module   : divisor_secuencial_if
//  Purpose  : Start/done handshake and operand/result bundle for the divider.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface divisor_secuencial_if #(
  parameter int N = 3
);
  logic           init;
  logic [2*N-1:0] DD;
  logic [N-1:0]   DR;
  logic [2*N-1:0] quo;
  logic [N-1:0]   rem;
  logic           done;
  logic           err;

  modport master (
    output init, DD, DR,
    input  quo, rem, done, err
  );

  modport slave (
    input  init, DD, DR,
    output quo, rem, done, err
  );
endinterface

`default_nettype wire

// File: rtl/divisor_secuencial.sv
// ============================================================================
//  Module   : divisor_secuencial
//  Purpose  : Restoring divider, 2N-bit dividend by N-bit divisor, one bit/clk.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module divisor_secuencial #(
  parameter int N = 3
) (
  input  wire                  clk,
  input  wire                  rst,
  divisor_secuencial_if.slave  bus
);

  localparam int CW = $clog2(2*N + 1);
  localparam logic [CW-1:0] C_LAST = CW'(2*N - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q,   cnt_d;
  logic [N:0]     pr_q,    pr_d;
  logic [2*N-1:0] sh_q,    sh_d;
  logic [N-1:0]   dr_q,    dr_d;
  logic [2*N-1:0] quo_q,   quo_d;
  logic [N-1:0]   rem_q,   rem_d;
  logic           done_q,  done_d;
  logic           err_q,   err_d;

  logic [N:0]     win;
  logic [N+1:0]   diff;
  logic           qbit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      pr_q    <= '0;
      sh_q    <= '0;
      dr_q    <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pr_q    <= pr_d;
      sh_q    <= sh_d;
      dr_q    <= dr_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pr_d    = pr_q;
    sh_d    = sh_q;
    dr_d    = dr_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    done_d  = done_q;
    err_d   = err_q;

    // Partial remainder stays below the divisor, so the shifted window fits N+1 bits.
    win  = {pr_q[N-1:0], sh_q[2*N-1]};
    diff = {1'b0, win} - {2'b00, dr_q};
    qbit = ~diff[N+1];

    case (state_q)
      IDLE: begin
        done_d = 1'b0;
        err_d  = 1'b0;
        if (bus.init) begin
          sh_d  = bus.DD;
          dr_d  = bus.DR;
          pr_d  = '0;
          cnt_d = '0;
          if (bus.DR == '0) begin
            err_d   = 1'b1;
            quo_d   = '1;
            rem_d   = '0;
            state_d = FIN;
          end else begin
            state_d = CALC;
          end
        end
      end

      CALC: begin
        pr_d  = qbit ? diff[N:0] : win;
        sh_d  = {sh_q[2*N-2:0], qbit};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == C_LAST) begin
          quo_d   = {sh_q[2*N-2:0], qbit};
          rem_d   = pr_d[N-1:0];
          done_d  = 1'b1;
          state_d = FIN;
        end
      end

      FIN: begin
        // Divide-by-zero arrives here with done low; it rises on the next held edge.
        if (bus.init) begin
          done_d = 1'b1;
        end else begin
          done_d  = 1'b0;
          err_d   = 1'b0;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
        done_d  = 1'b0;
        err_d   = 1'b0;
      end
    endcase
  end

  assign bus.quo  = quo_q;
  assign bus.rem  = rem_q;
  assign bus.done = done_q;
  assign bus.err  = err_q;

endmodule

`default_nettype wire
